// File: rtl/wbuff_bank_ctrl_if.sv
// -----------------------------------------------------------------------------
// wbuff_bank_ctrl_if
// Bundles the fill handshake, load/clear commands, weight-bank read/write
// ports and tap-register strobes of the weight buffer bank controller.
//
//   master : drives commands and fill words, observes bank/tap strobes
//   slave  : the controller (wbuff_bank_ctrl)
//
// Signals
//   fill_valid/fill_ready/fill_data/fill_clear : fill stream into the bank
//   load_start/load_base                       : tap-load command and window base
//   clear_req                                  : request to zero all tap registers
//   buf_wAddr/buf_wdata/buf_wEn_n              : bank write port (enable active-low)
//   buf_rAddr/buf_rEn_n                        : bank read port (enable active-low)
//   weight_load_en                             : one-hot tap capture strobe
//   clear_all_wregs                            : one-cycle tap clear pulse
//   load_busy/load_done                        : load status
//   err_flag                                   : sticky protocol error
// -----------------------------------------------------------------------------
interface wbuff_bank_ctrl_if #(
    parameter int NB_TAPS           = 11,
    parameter int BUFFER_DEPTH      = 72,
    parameter int BUFFER_WIDTH      = 16,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_DEPTH)
) ();
    logic                         fill_valid;
    logic                         fill_ready;
    logic [BUFFER_WIDTH-1:0]      fill_data;
    logic                         fill_clear;
    logic                         load_start;
    logic [BUFFER_ADDR_WIDTH-1:0] load_base;
    logic                         clear_req;
    logic [BUFFER_ADDR_WIDTH-1:0] buf_wAddr;
    logic [BUFFER_WIDTH-1:0]      buf_wdata;
    logic                         buf_wEn_n;
    logic [BUFFER_ADDR_WIDTH-1:0] buf_rAddr;
    logic                         buf_rEn_n;
    logic [NB_TAPS-1:0]           weight_load_en;
    logic                         clear_all_wregs;
    logic                         load_busy;
    logic                         load_done;
    logic                         err_flag;

    modport master (
        output fill_valid, fill_data, fill_clear, load_start, load_base, clear_req,
        input  fill_ready, buf_wAddr, buf_wdata, buf_wEn_n, buf_rAddr, buf_rEn_n,
        input  weight_load_en, clear_all_wregs, load_busy, load_done, err_flag
    );

    modport slave (
        input  fill_valid, fill_data, fill_clear, load_start, load_base, clear_req,
        output fill_ready, buf_wAddr, buf_wdata, buf_wEn_n, buf_rAddr, buf_rEn_n,
        output weight_load_en, clear_all_wregs, load_busy, load_done, err_flag
    );
endinterface

// File: rtl/wbuff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// wbuff_bank_ctrl
// Controller for a weight buffer bank. Streams fill words into the bank
// through a wrapping write pointer, and on a load command reads NB_TAPS
// consecutive bank entries (wrapping at BUFFER_DEPTH), strobing one tap
// capture bit per returned word. Tap clear requests arriving during a load
// are deferred until the controller is idle again.
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : wbuff_bank_ctrl_if.slave (fill, load, clear, bank ports, strobes)
//
// Optional feature: define WBUFF_CTRL_ERR_CHK_EN to enable the sticky
// err_flag (load_start while busy, or load accepted with fewer than NB_TAPS
// words in the bank). Without it err_flag is tied low.
// -----------------------------------------------------------------------------
module wbuff_bank_ctrl #(
    parameter int NB_TAPS           = 11,
    parameter int BUFFER_DEPTH      = 72,
    parameter int BUFFER_WIDTH      = 16,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_DEPTH)
) (
    input logic              clk,
    input logic              rst,
    wbuff_bank_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam int IDX_W = (NB_TAPS > 1) ? $clog2(NB_TAPS) : 1;
    localparam logic [IDX_W-1:0]             LAST_IDX = IDX_W'(NB_TAPS - 1);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] LAST_ADR = BUFFER_ADDR_WIDTH'(BUFFER_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                       state_q;
    logic [IDX_W-1:0]             idx_q;
    logic [BUFFER_ADDR_WIDTH-1:0] raddr_q;
    logic [NB_TAPS-1:0]           wle_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         pend_q;

    logic [BUFFER_ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [BUFFER_WIDTH-1:0]      wdata;

    logic full, fill_fire, clear_now, load_accept;

    assign full        = (count_q == CNT_W'(BUFFER_DEPTH));
    assign fill_fire   = bus.fill_valid & bus.fill_ready;
    // A clear (fresh or deferred) owns the idle cycle; a coincident load is dropped.
    assign clear_now   = ~rst & (state_q == IDLE) & (bus.clear_req | pend_q);
    assign load_accept = (state_q == IDLE) & bus.load_start & ~bus.clear_req & ~pend_q;
    assign wdata       = bus.fill_data;

    // Bank write port is combinational on the handshake.
    assign bus.fill_ready = ~rst & ~full & ~busy_q & ~bus.fill_clear;
    assign bus.buf_wEn_n  = ~fill_fire;
    assign bus.buf_wAddr  = wptr_q;
    assign bus.buf_wdata  = wdata;

    // Status/strobe outputs are forced inactive while reset is asserted.
    assign bus.buf_rEn_n       = rst | (state_q != READ);
    assign bus.buf_rAddr       = raddr_q;
    assign bus.weight_load_en  = rst ? '0 : wle_q;
    assign bus.load_busy       = ~rst & busy_q;
    assign bus.load_done       = ~rst & done_q;
    assign bus.clear_all_wregs = clear_now;

    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        if (bus.fill_clear) begin
            wptr_d  = '0;
            count_d = '0;
        end else if (fill_fire) begin
            wptr_d  = (wptr_q == LAST_ADR) ? '0 : wptr_q + BUFFER_ADDR_WIDTH'(1);
            count_d = full ? count_q : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            raddr_q <= '0;
            wle_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            wle_q  <= '0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_now) begin
                        pend_q <= 1'b0;
                    end else if (load_accept) begin
                        state_q <= READ;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        raddr_q <= bus.load_base;
                    end
                end
                READ: begin
                    // Read data returns next cycle, so the strobe for tap idx lags by one.
                    wle_q <= NB_TAPS'(1) << idx_q;
                    if (bus.clear_req) pend_q <= 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DRAIN;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        raddr_q <= (raddr_q == LAST_ADR) ? '0 : raddr_q + BUFFER_ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (bus.clear_req) pend_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WBUFF_CTRL_ERR_CHK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((busy_q & bus.load_start) ||
                     (load_accept && (count_q < CNT_W'(NB_TAPS)))) begin
            err_q <= 1'b1;
        end
    end
    assign bus.err_flag = err_q;
`else
    assign bus.err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_wbuff_bank_ctrl.sv
module tb_wbuff_bank_ctrl;
    localparam int NB = 11;
    localparam int D  = 72;
    localparam int W  = 16;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbuff_bank_ctrl_if #(.NB_TAPS(NB), .BUFFER_DEPTH(D), .BUFFER_WIDTH(W),
                         .BUFFER_ADDR_WIDTH(AW)) bus ();

    wbuff_bank_ctrl #(.NB_TAPS(NB), .BUFFER_DEPTH(D), .BUFFER_WIDTH(W),
                      .BUFFER_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load accepted in cycle L makes cycle L+k behave as:
    //   k=1..NB   : read of bank[(base+k-1) mod D]
    //   k=2..NB+1 : tap strobe bit k-2
    //   k=NB+1    : load_done
    //   busy for k=1..NB+1
    int m_wptr   = 0;
    int m_count  = 0;
    int m_load_t = -1000;
    int m_base   = 0;
    bit m_pend   = 1'b0;
    bit m_err    = 1'b0;

    int k;
    bit busy, wr, rd, e_rdy, e_clr, e_done, e_err;
    int e_wle;

    always @(negedge clk) begin
        k      = cyc - m_load_t;
        busy   = (k >= 1) && (k <= NB + 1);
        rd     = !rst && busy && (k <= NB);
        e_rdy  = !rst && (m_count < D) && !busy && !bus.fill_clear;
        wr     = bus.fill_valid && e_rdy;
        e_clr  = !rst && !busy && (bus.clear_req || m_pend);
        e_wle  = (!rst && k >= 2 && k <= NB + 1) ? (1 << (k - 2)) : 0;
        e_done = !rst && (k == NB + 1);
`ifdef WBUFF_CTRL_ERR_CHK_EN
        e_err  = m_err;
`else
        e_err  = 1'b0;
`endif
        chk("fill_ready", 32'(bus.fill_ready), 32'(e_rdy));
        chk("buf_wEn_n", 32'(bus.buf_wEn_n), 32'(!wr));
        if (wr) begin
            chk("buf_wAddr", 32'(bus.buf_wAddr), m_wptr);
            chk("buf_wdata", 32'(bus.buf_wdata), 32'(bus.fill_data));
        end
        chk("buf_rEn_n", 32'(bus.buf_rEn_n), 32'(!rd));
        if (rd) chk("buf_rAddr", 32'(bus.buf_rAddr), (m_base + k - 1) % D);
        chk("weight_load_en", 32'(bus.weight_load_en), e_wle);
        chk("load_busy", 32'(bus.load_busy), 32'(!rst && busy));
        chk("load_done", 32'(bus.load_done), 32'(e_done));
        chk("clear_all_wregs", 32'(bus.clear_all_wregs), 32'(e_clr));
        chk("err_flag", 32'(bus.err_flag), 32'(e_err));

        // state seen after the coming rising edge
        if (rst) begin
            m_wptr = 0; m_count = 0; m_pend = 0; m_err = 0; m_load_t = -1000;
        end else begin
            if (bus.fill_clear) begin
                m_wptr = 0; m_count = 0;
            end else if (wr) begin
                m_wptr  = (m_wptr + 1) % D;
                m_count = (m_count < D) ? m_count + 1 : D;
            end
            if (!busy) begin
                if (e_clr) m_pend = 0;
                else if (bus.load_start) begin
                    if (m_count < NB) m_err = 1;
                    m_load_t = cyc;
                    m_base   = int'(bus.load_base);
                end
            end else begin
                if (bus.clear_req)  m_pend = 1;
                if (bus.load_start) m_err  = 1;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int wrap_a [11] = '{68, 69, 70, 71, 0, 1, 2, 3, 4, 5, 6};

    initial begin
        bus.fill_valid = 0; bus.fill_data = '0; bus.fill_clear = 0;
        bus.load_start = 0; bus.load_base = '0; bus.clear_req = 0;
        rst = 1;
        repeat (3) tick();
        chk("rst_fill_ready", 32'(bus.fill_ready), 0);
        chk("rst_rEn_n", 32'(bus.buf_rEn_n), 1);
        rst = 0;
        #1;
        chk("post_rst_ready", 32'(bus.fill_ready), 1);

        // fill the whole bank, holding valid one cycle past full
        for (int n = 0; n <= D; n++) begin
            bus.fill_valid = 1;
            bus.fill_data  = W'(n);
            #1;
            if (n == 71) chk("last_wAddr", 32'(bus.buf_wAddr), 71);
            if (n == D)  chk("full_ready", 32'(bus.fill_ready), 0);
            tick();
        end
        bus.fill_valid = 0;

        // load from base 5; a second load_start mid-load must be ignored
        bus.load_base = 7'd5;
        bus.load_start = 1;
        tick();
        bus.load_start = 0;
        for (int j = 1; j <= 12; j++) begin
            #1;
            if (j <= 11) chk("rAddr_b5", 32'(bus.buf_rAddr), 32'(4 + j));
            if (j >= 2)  chk("wle_b5", 32'(bus.weight_load_en), 32'(1 << (j - 2)));
            chk("done_b5", 32'(bus.load_done), 32'(j == 12));
            bus.load_start = (j == 3);
            tick();
        end
        bus.load_start = 0;
        repeat (2) tick();

        // wrapping load with a clear request deferred to the idle cycle
        bus.load_base = 7'd68;
        bus.load_start = 1;
        tick();
        bus.load_start = 0;
        for (int j = 1; j <= 13; j++) begin
            #1;
            if (j <= 11) chk("rAddr_wrap", 32'(bus.buf_rAddr), 32'(wrap_a[j-1]));
            chk("clr_deferred", 32'(bus.clear_all_wregs), 32'(j == 13));
            bus.clear_req = (j == 4);
            tick();
        end
        bus.clear_req = 0;
        tick();

        // fill_clear beats a same-cycle fill
        bus.fill_valid = 1;
        bus.fill_data  = 16'hABCD;
        bus.fill_clear = 1;
        #1;
        chk("fclr_no_write", 32'(bus.buf_wEn_n), 1);
        tick();
        bus.fill_clear = 0;
        #1;
        chk("fclr_ready", 32'(bus.fill_ready), 1);
        chk("fclr_wAddr0", 32'(bus.buf_wAddr), 0);
        for (int n = 0; n < 5; n++) begin
            bus.fill_data = W'(16'h0100 + n);
            tick();
        end
        bus.fill_valid = 0;

        // short bank load, then reset mid-read
        bus.load_base = 7'd0;
        bus.load_start = 1;
        tick();
        bus.load_start = 0;
`ifdef WBUFF_CTRL_ERR_CHK_EN
        chk("err_set", 32'(bus.err_flag), 1);
`endif
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("abort_busy", 32'(bus.load_busy), 0);
        chk("abort_wle", 32'(bus.weight_load_en), 0);
        chk("abort_err", 32'(bus.err_flag), 0);
        repeat (14) tick();

        // clear in idle wins over a simultaneous load_start
        bus.clear_req = 1;
        bus.load_start = 1;
        #1;
        chk("idle_clr", 32'(bus.clear_all_wregs), 1);
        tick();
        bus.clear_req = 0;
        bus.load_start = 0;
        #1;
        chk("load_dropped", 32'(bus.load_busy), 0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wbuff_bank_ctrl.md
WBUFF_BANK_CTRL -- requirements
Module: wbuff_bank_ctrl

Interface
REQ-001 SHALL have parameter NB_TAPS, default 11, number of weight taps loaded per load command.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 72, number of bank entries.
REQ-003 SHALL have parameter BUFFER_WIDTH, default 16, bits per weight word.
REQ-004 SHALL have parameter BUFFER_ADDR_WIDTH, default ceil(log2(BUFFER_DEPTH)) (7), bank address width.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge (one clock; reset is synchronous and active-high).
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port fill_valid  input  1  fill word present.
REQ-008 SHALL have port fill_ready  output  1  fill word accepted when fill_valid&fill_ready.
REQ-009 SHALL have port fill_data  input  BUFFER_WIDTH  weight word to store.
REQ-010 SHALL have port fill_clear  input  1  pulse; rewind write pointer and entry count to 0.
REQ-011 SHALL have port load_start  input  1  pulse; begin loading NB_TAPS weights into tap registers.
REQ-012 SHALL have port load_base  input  BUFFER_ADDR_WIDTH  first bank address of the load window, sampled with load_start.
REQ-013 SHALL have port clear_req  input  1  request to zero all tap registers.
REQ-014 SHALL have ports buf_wAddr / buf_wdata / buf_wEn_n  output  BUFFER_ADDR_WIDTH / BUFFER_WIDTH / 1  bank write port, write enable active-low.
REQ-015 SHALL have ports buf_rAddr / buf_rEn_n  output  BUFFER_ADDR_WIDTH / 1  bank read port, read enable active-low, read data 1 cycle after enable.
REQ-016 SHALL have port weight_load_en  output  NB_TAPS  one-hot tap capture strobe.
REQ-017 SHALL have port clear_all_wregs  output  1  one-cycle tap register clear pulse.
REQ-018 SHALL have ports load_busy, load_done  output  1 each  load in progress; one-cycle completion pulse.
REQ-019 SHALL have port err_flag  output  1  sticky protocol error (see Configuration).

Function
REQ-020 Fill: on fill_valid&fill_ready, SHALL drive buf_wEn_n=0, buf_wAddr=wptr, buf_wdata=fill_data combinationally; wptr and count increment at the clock edge.
REQ-021 wptr SHALL wrap from BUFFER_DEPTH-1 to 0; count saturates at BUFFER_DEPTH.
REQ-022 fill_ready SHALL be 0 when count==BUFFER_DEPTH (full), when load_busy=1, or in the cycle fill_clear=1; else 1.
REQ-023 fill_clear SHALL take priority over a same-cycle fill handshake (no write issued; wptr=0, count=0 next cycle).
REQ-024 FSM states: IDLE, READ, DRAIN.
REQ-025 IDLE->READ on load_start=1 with clear_req=0 and no pending clear; load_busy=1 from the next cycle.
REQ-026 READ: for i=0..NB_TAPS-1 in consecutive cycles, drive buf_rEn_n=0, buf_rAddr=(load_base+i) mod BUFFER_DEPTH; after i=NB_TAPS-1 go to DRAIN.
REQ-027 weight_load_en[i] SHALL be asserted exactly in the cycle after read i is issued (READ cycle i+1, or DRAIN for i=NB_TAPS-1); all other bits 0.
REQ-028 DRAIN: assert weight_load_en[NB_TAPS-1] and load_done=1 for one cycle, then IDLE; load_busy=1 in READ and DRAIN only.
REQ-029 Load latency: load_start at cycle T -> load_done at cycle T+NB_TAPS+1.
REQ-030 load_start while load_busy=1 SHALL be ignored.
REQ-031 clear_req in IDLE SHALL produce clear_all_wregs=1 in the same cycle; simultaneous load_start is dropped.
REQ-032 clear_req while busy SHALL set a pending flag; clear_all_wregs pulses in the first IDLE cycle after load_done, then pending clears.
REQ-033 buf_rEn_n and buf_wEn_n SHALL be 1 whenever no access is issued.

Reset
REQ-034 On rst=1 at a clock edge: state=IDLE, wptr=0, count=0, pending clear=0, err_flag=0; abort any load with no load_done.
REQ-035 During and after reset until new stimulus: fill_ready=0 while rst=1, weight_load_en=0, clear_all_wregs=0, load_busy=0, load_done=0, buf_wEn_n=1, buf_rEn_n=1.

Configuration
REQ-036 Macro WBUFF_CTRL_ERR_CHK_EN defined: err_flag set (sticky until rst) on load_start while busy, or load_start accepted with count<NB_TAPS.
REQ-037 Macro undefined: err_flag tied 0, checking logic absent, all other behaviour identical.

Verification
REQ-038 Fill 72 words 0x0000..0x0047 with fill_valid held -> 72 writes at addr 0..71, fill_ready=0 after the 72nd; fill_clear -> wptr=0, fill_ready=1.
REQ-039 load_start, load_base=5 at cycle T -> rAddr 5..15 at T+1..T+11, weight_load_en one-hot bit i at T+2+i, load_done at T+12.
REQ-040 load_base=68 -> rAddr 68,69,70,71,0,1,..,6 (wrap).
REQ-041 clear_req at T+4 during load -> no clear until load_done; clear_all_wregs=1 at T+13 only.
REQ-042 rst=1 mid-READ -> next cycle all strobes 0, load_busy=0, no load_done; with WBUFF_CTRL_ERR_CHK_EN, load_start after fill of 5 words -> err_flag=1 and held.
